// File: rtl/execution_stage.sv
// rtl/execution_stage.sv - RV32I execute stage feeding the execute/memory pipeline register
// Define EXEC_MUL_EN to add the iterative M-extension multiplier (mul_from_decode, busy).
module execution_stage #(
  parameter int RESET_PC_BUBBLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_from_decode,
  input  logic [31:0] pc_from_decode,
  input  logic [31:0] rs1_data_from_decode,
  input  logic [31:0] rs2_data_from_decode,
  input  logic [31:0] imm_from_decode,
  input  logic [2:0]  funct3_from_decode,
  input  logic        funct7b5_from_decode,
  input  logic [4:0]  rd_from_decode,
  input  logic        alu_src_from_decode,
  input  logic        jalr_from_decode,
  input  logic        read_from_decode,
  input  logic        write_from_decode,
  input  logic        branch_from_decode,
  input  logic        u_branch_from_decode,
  input  logic        write_reg_from_decode,
  input  logic        select_from_decode,
  input  logic        stall,
  input  logic        flush,
`ifdef EXEC_MUL_EN
  input  logic        mul_from_decode,
`endif
  output logic [31:0] branch_addr_from_execution,
  output logic [31:0] result_from_execution,
  output logic [31:0] rs2_data_from_execution,
  output logic [2:0]  funct3_from_execution,
  output logic [4:0]  rd_from_execution,
  output logic        equal_from_execution,
  output logic        less_from_execution,
  output logic        greater_from_execution,
  output logic        read_from_execution,
  output logic        write_from_execution,
  output logic        branch_from_execution,
  output logic        u_branch_from_execution,
  output logic        write_reg_from_execution,
  output logic        select_from_execution,
  output logic        busy_from_execution
);

  typedef struct packed {
    logic [31:0] branch_addr;
    logic [31:0] result;
    logic [31:0] rs2_data;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        equal, less, greater;
    logic        read, write, branch, u_branch, write_reg, select;
  } ex_t;

  // A value of 0 is reserved; only the bubble reset is meaningful.
  localparam logic RST_CTRL = (RESET_PC_BUBBLE == 0);

  ex_t         ex_q, ex_d;
  logic [31:0] op_b, alu_result, sum_ri;
  logic        lt_s, lt_u, eq;

  always_comb begin
    op_b       = alu_src_from_decode ? imm_from_decode : rs2_data_from_decode;
    sum_ri     = rs1_data_from_decode + imm_from_decode;
    alu_result = '0;
    if (read_from_decode || write_from_decode) alu_result = sum_ri;
    else if (u_branch_from_decode) alu_result = pc_from_decode + 32'd4;
    else begin
      case (funct3_from_decode)
        3'b000: alu_result = (funct7b5_from_decode && !alu_src_from_decode) ?
                             rs1_data_from_decode - op_b : rs1_data_from_decode + op_b;
        3'b001: alu_result = rs1_data_from_decode << op_b[4:0];
        3'b010: alu_result = {31'b0, $signed(rs1_data_from_decode) < $signed(op_b)};
        3'b011: alu_result = {31'b0, rs1_data_from_decode < op_b};
        3'b100: alu_result = rs1_data_from_decode ^ op_b;
        3'b101: alu_result = funct7b5_from_decode ?
                             32'($signed(rs1_data_from_decode) >>> op_b[4:0]) :
                             rs1_data_from_decode >> op_b[4:0];
        3'b110: alu_result = rs1_data_from_decode | op_b;
        default: alu_result = rs1_data_from_decode & op_b;
      endcase
    end
  end

  always_comb begin
    eq   = (rs1_data_from_decode == rs2_data_from_decode);
    lt_s = $signed(rs1_data_from_decode) < $signed(rs2_data_from_decode);
    lt_u = rs1_data_from_decode < rs2_data_from_decode;
    ex_d             = '0;
    ex_d.branch_addr = jalr_from_decode ? (sum_ri & 32'hFFFF_FFFE)
                                        : (pc_from_decode + imm_from_decode);
    ex_d.result      = alu_result;
    ex_d.rs2_data    = rs2_data_from_decode;
    ex_d.funct3      = funct3_from_decode;
    ex_d.rd          = rd_from_decode;
    ex_d.equal       = eq;
    ex_d.less        = funct3_from_decode[1] ? lt_u : lt_s;
    ex_d.greater     = !eq && !(funct3_from_decode[1] ? lt_u : lt_s);
    ex_d.read        = read_from_decode;
    ex_d.write       = write_from_decode;
    ex_d.branch      = branch_from_decode;
    ex_d.u_branch    = u_branch_from_decode;
    ex_d.write_reg   = write_reg_from_decode;
    ex_d.select      = select_from_decode;
  end

`ifdef EXEC_MUL_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
  mul_state_t  state;
  logic        busy_q, neg, hi_sel, a_neg, b_neg;
  logic [4:0]  cnt;
  logic [63:0] prod, mcand, prod_fix;
  logic [31:0] mplier, abs_a, abs_b;
  ex_t         mul_pkt;

  // Multiply on magnitudes, then restore the sign once in DONE.
  always_comb begin
    a_neg    = !funct3_from_decode[2] && !(funct3_from_decode[1] && funct3_from_decode[0])
               && rs1_data_from_decode[31];
    b_neg    = (funct3_from_decode[2:1] == 2'b00) && rs2_data_from_decode[31];
    abs_a    = a_neg ? -rs1_data_from_decode : rs1_data_from_decode;
    abs_b    = b_neg ? -rs2_data_from_decode : rs2_data_from_decode;
    prod_fix = neg ? -prod : prod;
    mul_pkt  = ex_d;
    mul_pkt.result = hi_sel ? prod_fix[63:32] : prod_fix[31:0];
  end

  assign busy_from_execution = busy_q;
`else
  assign busy_from_execution = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
      {ex_q.read, ex_q.write, ex_q.branch, ex_q.u_branch, ex_q.write_reg, ex_q.select} <= {6{RST_CTRL}};
`ifdef EXEC_MUL_EN
      state  <= IDLE;
      busy_q <= 1'b0;
      cnt    <= '0;
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      hi_sel <= 1'b0;
`endif
    end else if (flush) begin
      ex_q <= '0;
`ifdef EXEC_MUL_EN
      state  <= IDLE;
      busy_q <= 1'b0;
    end else if (state == RUN) begin
      if (mplier[0]) prod <= prod + mcand;
      mcand  <= {mcand[62:0], 1'b0};
      mplier <= mplier >> 1;
      cnt    <= cnt + 5'd1;
      if (cnt == 5'd31) state <= DONE;
    end else if (state == DONE) begin
      if (!stall) begin
        ex_q   <= mul_pkt;
        state  <= IDLE;
        busy_q <= 1'b0;
      end
    end else if (stall) begin
      ex_q <= ex_q;
    end else if (valid_from_decode && mul_from_decode) begin
      ex_q   <= '0;
      prod   <= '0;
      mcand  <= {32'b0, abs_a};
      mplier <= abs_b;
      cnt    <= '0;
      neg    <= a_neg ^ b_neg;
      hi_sel <= (funct3_from_decode != 3'b000);
      state  <= RUN;
      busy_q <= 1'b1;
`else
    end else if (stall) begin
      ex_q <= ex_q;
`endif
    end else if (valid_from_decode) begin
      ex_q <= ex_d;
    end else begin
      ex_q <= '0;
    end
  end

  assign branch_addr_from_execution = ex_q.branch_addr;
  assign result_from_execution      = ex_q.result;
  assign rs2_data_from_execution    = ex_q.rs2_data;
  assign funct3_from_execution      = ex_q.funct3;
  assign rd_from_execution          = ex_q.rd;
  assign equal_from_execution       = ex_q.equal;
  assign less_from_execution        = ex_q.less;
  assign greater_from_execution     = ex_q.greater;
  assign read_from_execution        = ex_q.read;
  assign write_from_execution       = ex_q.write;
  assign branch_from_execution      = ex_q.branch;
  assign u_branch_from_execution    = ex_q.u_branch;
  assign write_reg_from_execution   = ex_q.write_reg;
  assign select_from_execution      = ex_q.select;

endmodule

// File: tb/tb_execution_stage.sv
// tb/tb_execution_stage.sv - randomized and directed bench for execution_stage against a reference model
// Multiplier tests are compiled in when EXEC_MUL_EN is defined.
module tb_execution_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0, f7 = 1'b0, asrc = 1'b0, jalr = 1'b0;
  logic        stall = 1'b0, flush = 1'b0;
  logic [31:0] pc = '0, rs1 = '0, rs2 = '0, imm = '0;
  logic [2:0]  f3 = '0;
  logic [4:0]  rd = '0;
  logic [5:0]  ctl = '0;  // {read, write, branch, u_branch, write_reg, select}
`ifdef EXEC_MUL_EN
  logic        mul = 1'b0;
  int          n;
`endif

  logic [31:0] o_baddr, o_res, o_rs2;
  logic [2:0]  o_f3;
  logic [4:0]  o_rd;
  logic        o_eq, o_lt, o_gt, o_busy;
  logic [5:0]  o_ctl;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b1;

  always #5 clk = ~clk;

  execution_stage #(.RESET_PC_BUBBLE(1)) dut (
    .clk(clk), .rst(rst), .valid_from_decode(valid), .pc_from_decode(pc),
    .rs1_data_from_decode(rs1), .rs2_data_from_decode(rs2), .imm_from_decode(imm),
    .funct3_from_decode(f3), .funct7b5_from_decode(f7), .rd_from_decode(rd),
    .alu_src_from_decode(asrc), .jalr_from_decode(jalr),
    .read_from_decode(ctl[5]), .write_from_decode(ctl[4]), .branch_from_decode(ctl[3]),
    .u_branch_from_decode(ctl[2]), .write_reg_from_decode(ctl[1]), .select_from_decode(ctl[0]),
    .stall(stall), .flush(flush),
`ifdef EXEC_MUL_EN
    .mul_from_decode(mul),
`endif
    .branch_addr_from_execution(o_baddr), .result_from_execution(o_res),
    .rs2_data_from_execution(o_rs2), .funct3_from_execution(o_f3), .rd_from_execution(o_rd),
    .equal_from_execution(o_eq), .less_from_execution(o_lt), .greater_from_execution(o_gt),
    .read_from_execution(o_ctl[5]), .write_from_execution(o_ctl[4]),
    .branch_from_execution(o_ctl[3]), .u_branch_from_execution(o_ctl[2]),
    .write_reg_from_execution(o_ctl[1]), .select_from_execution(o_ctl[0]),
    .busy_from_execution(o_busy)
  );

  typedef struct packed {
    logic [31:0] baddr, res, rs2;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        eq, lt, gt;
    logic [5:0]  ctl;
  } exp_t;

  exp_t exp_q = '0;

  function automatic exp_t compute();
    exp_t e;
    logic [31:0] b;
    int sh;
    b  = asrc ? imm : rs2;
    sh = int'(b % 32);
    if (ctl[5] || ctl[4]) e.res = rs1 + imm;
    else if (ctl[2]) e.res = pc + 4;
    else begin
      case (f3)
        3'd0: e.res = (f7 && !asrc) ? rs1 - b : rs1 + b;
        3'd1: e.res = rs1 << sh;
        3'd2: e.res = (int'(rs1) < int'(b)) ? 32'd1 : 32'd0;
        3'd3: e.res = (rs1 < b) ? 32'd1 : 32'd0;
        3'd4: e.res = rs1 ^ b;
        3'd5: e.res = f7 ? 32'(int'(rs1) >>> sh) : rs1 >> sh;
        3'd6: e.res = rs1 | b;
        default: e.res = rs1 & b;
      endcase
    end
    e.baddr = jalr ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
    e.rs2   = rs2;
    e.f3    = f3;
    e.rd    = rd;
    e.eq    = (rs1 == rs2);
    e.lt    = f3[1] ? (rs1 < rs2) : (int'(rs1) < int'(rs2));
    e.gt    = f3[1] ? (rs1 > rs2) : (int'(rs1) > int'(rs2));
    e.ctl   = ctl;
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) exp_q <= '0;
    else if (flush) exp_q <= '0;
    else if (stall) exp_q <= exp_q;
    else if (valid) exp_q <= compute();
    else exp_q <= '0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("branch_addr", o_baddr, exp_q.baddr);
      chk("result", o_res, exp_q.res);
      chk("rs2_data", o_rs2, exp_q.rs2);
      chk("funct3", 32'(o_f3), 32'(exp_q.f3));
      chk("rd", 32'(o_rd), 32'(exp_q.rd));
      chk("flags", 32'({o_eq, o_lt, o_gt}), 32'({exp_q.eq, exp_q.lt, exp_q.gt}));
      chk("ctrl", 32'(o_ctl), 32'(exp_q.ctl));
      chk("busy", 32'(o_busy), 32'd0);
    end
  end

  task automatic issue(input logic [31:0] p, a, b, i, input logic [2:0] f, input logic f7b,
                       input logic [4:0] d, input logic as, input logic jr, input logic [5:0] c);
    pc = p; rs1 = a; rs2 = b; imm = i; f3 = f; f7 = f7b; rd = d; asrc = as; jalr = jr; ctl = c;
    valid = 1'b1; stall = 1'b0; flush = 1'b0;
    @(posedge clk); #2;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk); #1;
    chk("reset_result", o_res, 32'd0);
    chk("reset_ctrl", 32'(o_ctl), 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;

    issue(32'h0, 32'd5, 32'd0, 32'd7, 3'b000, 1'b0, 5'd1, 1'b1, 1'b0, 6'b000010);
    chk("addi_result", o_res, 32'd12);
    chk("addi_write_reg", 32'(o_ctl[1]), 32'd1);
    chk("model_addi", exp_q.res, 32'd12);
    issue(32'h0, 32'd3, 32'd5, 32'd0, 3'b000, 1'b1, 5'd2, 1'b0, 1'b0, 6'b000010);
    chk("sub_result", o_res, 32'hFFFF_FFFE);
    issue(32'h0, 32'h8000_0000, 32'd0, 32'd4, 3'b101, 1'b1, 5'd3, 1'b1, 1'b0, 6'b000010);
    chk("sra_result", o_res, 32'hF800_0000);
    chk("model_sra", exp_q.res, 32'hF800_0000);
    issue(32'h0, 32'h100, 32'd0, 32'hFFFF_FFFC, 3'b010, 1'b0, 5'd7, 1'b1, 1'b0, 6'b100010);
    chk("load_addr", o_res, 32'h0000_00FC);
    chk("load_funct3", 32'(o_f3), 32'd2);
    chk("load_rd", 32'(o_rd), 32'd7);
    issue(32'h40, 32'd9, 32'd9, 32'h10, 3'b000, 1'b0, 5'd0, 1'b0, 1'b0, 6'b001000);
    chk("beq_addr", o_baddr, 32'h50);
    chk("beq_equal", 32'(o_eq), 32'd1);
    issue(32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0, 3'b110, 1'b0, 5'd0, 1'b0, 1'b0, 6'b001000);
    chk("bltu_flags", 32'({o_eq, o_lt, o_gt}), 32'b001);
    issue(32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0, 3'b100, 1'b0, 5'd0, 1'b0, 1'b0, 6'b001000);
    chk("blt_flags", 32'({o_eq, o_lt, o_gt}), 32'b010);
    chk("model_blt", 32'({exp_q.eq, exp_q.lt, exp_q.gt}), 32'b010);
    issue(32'h20, 32'h1001, 32'd0, 32'd2, 3'b000, 1'b0, 5'd1, 1'b1, 1'b1, 6'b000110);
    chk("jalr_addr", o_baddr, 32'h1002);
    chk("jalr_link", o_res, 32'h24);

    stall = 1'b1; rs1 = 32'hDEAD_BEEF; pc = 32'h1234;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      chk("stall_result", o_res, 32'h24);
      chk("stall_addr", o_baddr, 32'h1002);
    end
    flush = 1'b1;
    @(posedge clk); #2;
    chk("flush_stall_result", o_res, 32'd0);
    chk("flush_stall_ctrl", 32'(o_ctl), 32'd0);
    flush = 1'b0; stall = 1'b0;

    issue(32'h0, 32'd5, 32'd0, 32'd7, 3'b000, 1'b0, 5'd1, 1'b1, 1'b0, 6'b000010);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_result", o_res, 32'd0);
    chk("async_rst_write_reg", 32'(o_ctl[1]), 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;

`ifdef EXEC_MUL_EN
    check_en = 1'b0;
    mul = 1'b1;
    issue(32'h0, 32'hFFFF_FFFF, 32'd2, 32'd0, 3'b001, 1'b0, 5'd4, 1'b0, 1'b0, 6'b000010);
    chk("mulh_busy_start", 32'(o_busy), 32'd1);
    n = 0;
    while (o_busy && n < 100) begin @(posedge clk); #2; n++; end
    chk("mulh_busy_cycles", n, 33);
    chk("mulh_result", o_res, 32'hFFFF_FFFF);
    mul = 1'b1;
    issue(32'h0, 32'd7, 32'd6, 32'd0, 3'b000, 1'b0, 5'd5, 1'b0, 1'b0, 6'b000010);
    n = 0;
    while (o_busy && n < 100) begin @(posedge clk); #2; n++; end
    chk("mul_busy_cycles", n, 33);
    chk("mul_result", o_res, 32'd42);
    issue(32'h0, 32'd7, 32'd6, 32'd0, 3'b000, 1'b0, 5'd5, 1'b0, 1'b0, 6'b000010);
    repeat (9) begin @(posedge clk); #2; end
    flush = 1'b1;
    @(posedge clk); #2;
    chk("mul_flush_busy", 32'(o_busy), 32'd0);
    chk("mul_flush_result", o_res, 32'd0);
    flush = 1'b0; mul = 1'b0; valid = 1'b0;
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    check_en = 1'b1;
`endif

    for (int k = 0; k < 600; k++) begin
      @(negedge clk); #1;
      valid = ($urandom_range(0, 7) != 0);
      stall = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 9) == 0);
      pc    = $urandom & 32'hFFFF_FFFC;
      rs1   = $urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom;
      rs2   = $urandom_range(0, 3) == 0 ? rs1 : $urandom;
      imm   = $urandom_range(0, 1) == 0 ? $urandom_range(0, 63) : $urandom;
      f3    = 3'($urandom_range(0, 7));
      f7    = 1'($urandom_range(0, 1));
      rd    = 5'($urandom_range(0, 31));
      asrc  = 1'($urandom_range(0, 1));
      jalr  = 1'($urandom_range(0, 1));
      ctl   = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
    end
    @(negedge clk); #1;
    valid = 1'b0; stall = 1'b0; flush = 1'b0;
    @(negedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
